// File: rtl/abajur_pkg.sv
// rtl/abajur_pkg.sv - shared types and helpers for the lamp-shade mode controller
package abajur_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MANUAL  = 3'd1,
        ALL_ON  = 3'd2,
        BLINK   = 3'd3,
        BREATHE = 3'd4
    } mode_e;

    localparam logic [3:0] DISP_NONE = 4'hA;
    localparam int         SW_MAX    = 15;

    // Index of the highest set bit; DISP_NONE when no bit is set.
    function automatic logic [3:0] hi_index(input logic [SW_MAX-1:0] s);
        logic [3:0] idx;
        idx = DISP_NONE;
        for (int i = 0; i < SW_MAX; i++) begin
            if (s[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/abajur_mode_ctrl_sw_debounce.sv
// rtl/abajur_mode_ctrl_sw_debounce.sv - per-bit 2-flop synchroniser and stability counter
module sw_debounce #(
    parameter int WIDTH      = 10,
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_db_o
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A single bit that changes while differing from db_q becomes equal to it,
    // so the equality test alone also covers the "synced value changed" restart.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sw_db_o = db_q;

endmodule

// File: rtl/abajur_mode_ctrl.sv
// rtl/abajur_mode_ctrl.sv - lamp-shade controller: debounce, mode priority, motor gating, LED effects
module abajur_mode_ctrl
    import abajur_pkg::*;
#(
    parameter int  N_MOTOR     = 3,
    parameter int  N_LED       = 4,
    parameter int  DEB_CYCLES  = 500000,
    parameter int  BLINK_HALF  = 12500000,
    parameter int  PWM_BITS    = 8,
    parameter int  STEP_CYCLES = 50000,
    localparam int N_SW        = N_MOTOR + N_LED + 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SW-1:0]    sw,
    input  logic [N_MOTOR-1:0] motor_pwm_i,
    output logic [N_MOTOR-1:0] motor_pwm_o,
    output logic [N_LED-1:0]   led_o,
    output logic [3:0]         disp_code
);

    localparam int PH_W   = PWM_BITS + 1;
    localparam int PH_OFF = (2 ** PH_W) / N_LED;
    localparam int BL_W   = $clog2(BLINK_HALF);
    localparam int ST_W   = $clog2(STEP_CYCLES + 1);

    logic [N_SW-1:0]     sw_db;
    mode_e               mode_q, mode_d;
    logic [N_MOTOR-1:0]  en_q, en_d, motor_q, motor_d;
    logic [N_LED-1:0]    man_q, man_d, led_q, led_d, breathe_led;
    logic [3:0]          disp_q, disp_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty;
    logic [PH_W-1:0]     ph_q, ph_d, ph_j;
    logic [ST_W-1:0]     step_q, step_d;

    sw_debounce #(
        .WIDTH      (N_SW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw),
        .sw_db_o (sw_db)
    );

    // Channels are phase-staggered evenly around the triangle period.
    always_comb begin
        breathe_led = '0;
        ph_j        = '0;
        duty        = '0;
        for (int j = 0; j < N_LED; j++) begin
            ph_j           = ph_q + PH_W'(j * PH_OFF);
            duty           = ph_j[PWM_BITS] ? ~ph_j[PWM_BITS-1:0] : ph_j[PWM_BITS-1:0];
            breathe_led[j] = (pwm_cnt_q < duty);
        end
    end

    always_comb begin
        mode_d      = IDLE;
        en_d        = '0;
        man_d       = '0;
        disp_d      = hi_index(SW_MAX'(sw_db));
        motor_d     = motor_pwm_i & en_q;
        led_d       = '0;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        pwm_cnt_d   = '0;
        ph_d        = '0;
        step_d      = '0;

        if (sw_db[0])      mode_d = BREATHE;
        else if (sw_db[1]) mode_d = BLINK;
        else if (sw_db[2]) mode_d = ALL_ON;
        else if (|sw_db)   mode_d = MANUAL;

        for (int k = 0; k < N_MOTOR; k++) en_d[k] = sw_db[N_SW-1-k];
        for (int j = 0; j < N_LED; j++)   man_d[j] = sw_db[N_SW-1-N_MOTOR-j];

        if (mode_q == BLINK) begin
            blink_ph_d = blink_ph_q;
            if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
                blink_ph_d = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (mode_q == BREATHE) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            ph_d      = ph_q;
            if (step_q == ST_W'(STEP_CYCLES - 1)) begin
                ph_d = ph_q + 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end

        case (mode_q)
            MANUAL:  led_d = man_q;
            ALL_ON:  led_d = '1;
            BLINK:   led_d = {N_LED{blink_ph_q}};
            BREATHE: led_d = breathe_led;
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= IDLE;
            en_q        <= '0;
            man_q       <= '0;
            disp_q      <= DISP_NONE;
            motor_q     <= '0;
            led_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            pwm_cnt_q   <= '0;
            ph_q        <= '0;
            step_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            en_q        <= en_d;
            man_q       <= man_d;
            disp_q      <= disp_d;
            motor_q     <= motor_d;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            pwm_cnt_q   <= pwm_cnt_d;
            ph_q        <= ph_d;
            step_q      <= step_d;
        end
    end

    assign motor_pwm_o = motor_q;
    assign led_o       = led_q;
    assign disp_code   = disp_q;

endmodule

// File: tb/tb_abajur_mode_ctrl.sv
// tb/tb_abajur_mode_ctrl.sv - self-checking bench for abajur_mode_ctrl
module tb_abajur_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic [2:0] motor_pwm_i;
    logic [2:0] motor_pwm_o;
    logic [3:0] led_o;
    logic [3:0] disp_code;

    int total = 0;
    int bad   = 0;

    abajur_mode_ctrl #(
        .N_MOTOR     (3),
        .N_LED       (4),
        .DEB_CYCLES  (4),
        .BLINK_HALF  (8),
        .PWM_BITS    (4),
        .STEP_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .motor_pwm_i (motor_pwm_i),
        .motor_pwm_o (motor_pwm_o),
        .led_o       (led_o),
        .disp_code   (disp_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        logic [2:0] mp;
        logic [2:0] m;
        logic [3:0] l;
        logic [3:0] d;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [9:0] v);
        @(negedge clk);
        sw = v;
    endtask

    // Expected LED pattern t cycles into BREATHE: ph = t/2, pwm_cnt = t mod 16.
    function automatic logic [3:0] exp_breathe(input int t);
        logic [3:0] r;
        int ph, pwm, phj, duty;
        ph  = (t / 2) % 32;
        pwm = t % 16;
        for (int j = 0; j < 4; j++) begin
            phj  = (ph + 8 * j) % 32;
            duty = (phj >= 16) ? (15 - (phj % 16)) : phj;
            r[j] = (pwm < duty);
        end
        return r;
    endfunction

    initial begin
        vecs[0] = '{sw: 10'h000, mp: 3'b111, m: 3'b000, l: 4'b0000, d: 4'hA};
        vecs[1] = '{sw: 10'h200, mp: 3'b111, m: 3'b001, l: 4'b0000, d: 4'h9};
        vecs[2] = '{sw: 10'h300, mp: 3'b010, m: 3'b010, l: 4'b0000, d: 4'h9};
        vecs[3] = '{sw: 10'h180, mp: 3'b111, m: 3'b110, l: 4'b0000, d: 4'h8};
        vecs[4] = '{sw: 10'h048, mp: 3'b111, m: 3'b000, l: 4'b1001, d: 4'h6};
        vecs[5] = '{sw: 10'h04C, mp: 3'b111, m: 3'b000, l: 4'b1111, d: 4'h6};
        vecs[6] = '{sw: 10'h0A0, mp: 3'b110, m: 3'b100, l: 4'b0010, d: 4'h7};
        vecs[7] = '{sw: 10'h010, mp: 3'b000, m: 3'b000, l: 4'b0100, d: 4'h4};
        vecs[8] = '{sw: 10'h284, mp: 3'b111, m: 3'b101, l: 4'b1111, d: 4'h9};

        rst_n       = 1'b0;
        sw          = '0;
        motor_pwm_i = 3'b111;
        tick(3);
        check("reset_motor", 32'(motor_pwm_o), 32'h0);
        check("reset_led", 32'(led_o), 32'h0);
        check("reset_disp", 32'(disp_code), 32'hA);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);

        // 3-cycle glitch on sw[6] must be filtered out
        set_sw(10'h040);
        repeat (3) @(negedge clk);
        sw = 10'h000;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_led", 32'(led_o), 32'h0);
            check("glitch_disp", 32'(disp_code), 32'hA);
        end

        // exact latency from raw edge to motor output
        set_sw(10'h200);
        tick(7);
        check("latency_motor_early", 32'(motor_pwm_o), 32'h0);
        tick(1);
        check("latency_motor", 32'(motor_pwm_o), 32'h1);
        check("latency_disp", 32'(disp_code), 32'h9);

        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            sw          = vecs[v].sw;
            motor_pwm_i = vecs[v].mp;
            tick(12);
            check($sformatf("vec%0d_motor", v), 32'(motor_pwm_o), 32'(vecs[v].m));
            check($sformatf("vec%0d_led", v), 32'(led_o), 32'(vecs[v].l));
            check($sformatf("vec%0d_disp", v), 32'(disp_code), 32'(vecs[v].d));
        end

        motor_pwm_i = 3'b000;
        set_sw(10'h040);
        tick(12);
        check("manual_led", 32'(led_o), 32'h1);

        // BLINK entry: 8 off, 8 on, 8 off
        set_sw(10'h042);
        tick(7);
        for (int i = 8; i < 32; i++) begin
            tick(1);
            check($sformatf("blink_c%0d", i), 32'(led_o), ((((i - 8) / 8) % 2) == 1) ? 32'hF : 32'h0);
        end
        check("blink_disp", 32'(disp_code), 32'h6);
        set_sw(10'h040);
        tick(8);
        check("blink_exit_led", 32'(led_o), 32'h1);
        set_sw(10'h042);
        tick(7);
        for (int i = 8; i <= 16; i++) begin
            tick(1);
            check($sformatf("reblink_c%0d", i), 32'(led_o), (i >= 16) ? 32'hF : 32'h0);
        end

        // BREATHE from BLINK
        set_sw(10'h041);
        tick(7);
        for (int t = 0; t < 48; t++) begin
            tick(1);
            check($sformatf("breathe_t%0d", t), 32'(led_o), 32'(exp_breathe(t)));
        end
        check("breathe_disp", 32'(disp_code), 32'h6);

        // reset mid-breathe, then restart from cleared counters
        @(negedge clk);
        rst_n = 1'b0;
        tick(1);
        check("midrst_motor", 32'(motor_pwm_o), 32'h0);
        check("midrst_led", 32'(led_o), 32'h0);
        check("midrst_disp", 32'(disp_code), 32'hA);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("postrst_led", 32'(led_o), 32'h0);
            check("postrst_disp", 32'(disp_code), 32'hA);
        end
        tick(1);
        for (int t = 0; t < 8; t++) begin
            tick(1);
            check($sformatf("rebreathe_t%0d", t), 32'(led_o), 32'(exp_breathe(t)));
        end

        set_sw(10'h000);
        tick(12);
        check("idle_led", 32'(led_o), 32'h0);
        check("idle_disp", 32'(disp_code), 32'hA);

        // BREATHE beats BLINK; releasing sw[0] falls back to BLINK off phase
        set_sw(10'h003);
        tick(7);
        for (int t = 0; t < 16; t++) begin
            tick(1);
            check($sformatf("prio_t%0d", t), 32'(led_o), 32'(exp_breathe(t)));
        end
        check("prio_disp", 32'(disp_code), 32'h1);
        set_sw(10'h002);
        tick(7);
        for (int i = 8; i < 24; i++) begin
            tick(1);
            check($sformatf("fallback_c%0d", i), 32'(led_o), (i >= 16) ? 32'hF : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
